// File: rtl/bus_force_ctrl.sv
// Bus force/release controller: round-robin arbitrated force ops over a WIDTH-bit bus.
// Optional FORCE_CTRL_HOLD_ON_RELEASE_EN keeps released bits on their forced value until in_we.
module bus_force_ctrl #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_we,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_rel,
  input  logic [NREQ*WIDTH-1:0] req_mask,
  input  logic [NREQ*WIDTH-1:0] req_val,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      bus_out,
  output logic [WIDTH-1:0]      forced_mask,
  output logic                  busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, ACK = 2'd2} state_t;
  state_t state_q, state_d;

  logic [PW-1:0]    ptr_q, ptr_d, win_q, win_d, pick, cand;
  logic             found;
  logic             op_rel_q, op_rel_d;
  logic [WIDTH-1:0] op_mask_q, op_mask_d, op_val_q, op_val_d;
  logic [WIDTH-1:0] fmask_q, fmask_d, fval_q, fval_d, drive;

  // Round-robin search starting at the requester after the last winner
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    op_rel_d  = op_rel_q;
    op_mask_d = op_mask_q;
    op_val_d  = op_val_q;
    case (state_q)
      IDLE: if (found) begin
        state_d   = APPLY;
        win_d     = pick;
        op_rel_d  = req_rel[pick];
        op_mask_d = req_mask[int'(pick)*WIDTH +: WIDTH];
        op_val_d  = req_val[int'(pick)*WIDTH +: WIDTH];
      end
      APPLY: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        ptr_d   = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    gnt  = '0;
    if (state_q == ACK) gnt[win_q] = 1'b1;
  end

  always_comb begin
    fmask_d = fmask_q;
    fval_d  = fval_q;
    if (state_q == APPLY) begin
      if (op_rel_q) begin
        fmask_d = fmask_q & ~op_mask_q;
      end else begin
        fmask_d = fmask_q | op_mask_q;
        fval_d  = (fval_q & ~op_mask_q) | (op_val_q & op_mask_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      win_q     <= '0;
      op_rel_q  <= 1'b0;
      op_mask_q <= '0;
      op_val_q  <= '0;
      fmask_q   <= '0;
      fval_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      op_rel_q  <= op_rel_d;
      op_mask_q <= op_mask_d;
      op_val_q  <= op_val_d;
      fmask_q   <= fmask_d;
      fval_q    <= fval_d;
    end
  end

`ifdef FORCE_CTRL_HOLD_ON_RELEASE_EN
  logic [WIDTH-1:0] held_q, held_d;

  // in_we clears old holds first so a release on the same edge still latches
  always_comb begin
    held_d = in_we ? '0 : held_q;
    if (state_q == APPLY) begin
      if (op_rel_q) held_d = held_d | (op_mask_q & fmask_q);
      else          held_d = held_d & ~op_mask_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) held_q <= '0;
    else        held_q <= held_d;
  end

  assign drive = fmask_q | held_q;
`else
  logic unused_we;
  assign unused_we = in_we;
  assign drive     = fmask_q;
`endif

  assign forced_mask = fmask_q;
  assign bus_out     = (drive & fval_q) | (~drive & in_data);
endmodule

// File: tb/tb_bus_force_ctrl.sv
// Self-checking bench for bus_force_ctrl: directed scenarios plus randomized traffic vs a timing model.
module tb_bus_force_ctrl;
  localparam int W = 4;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_we;
  logic [N-1:0]   req, req_rel;
  logic [N*W-1:0] req_mask, req_val;
  logic [N-1:0]   gnt;
  logic [W-1:0]   bus_out, forced_mask;
  logic           busy;

  int checks = 0;
  int errors = 0;

  bus_force_ctrl #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_we(in_we),
    .req(req), .req_rel(req_rel), .req_mask(req_mask), .req_val(req_val),
    .gnt(gnt), .bus_out(bus_out), .forced_mask(forced_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Timing model: an accepted op completes (visible + granted) two cycles after
  // its request cycle, and the controller takes no new op until the cycle after.
  logic [W-1:0] m_forced = '0, m_fval = '0, m_held = '0;
  logic [W-1:0] op_mask, op_val;
  bit           op_rel, have_op = 1'b0, was_idle, picked;
  int           m_last = N-1, op_win = 0, op_gnt = 0, cyc = 0, cnd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_forced = '0; m_fval = '0; m_held = '0;
      m_last = N-1; have_op = 1'b0;
    end else begin
      was_idle = !have_op;
`ifdef FORCE_CTRL_HOLD_ON_RELEASE_EN
      if (in_we) m_held = '0;
`endif
      if (have_op && cyc + 1 == op_gnt) begin
        if (op_rel) begin
`ifdef FORCE_CTRL_HOLD_ON_RELEASE_EN
          m_held = m_held | (op_mask & m_forced);
`endif
          m_forced = m_forced & ~op_mask;
        end else begin
          m_forced = m_forced | op_mask;
          m_fval   = (m_fval & ~op_mask) | (op_val & op_mask);
          m_held   = m_held & ~op_mask;
        end
      end
      if (have_op && cyc == op_gnt) begin
        m_last  = op_win;
        have_op = 1'b0;
      end
      if (was_idle && req != '0) begin
        picked = 1'b0;
        for (int j = 1; j <= N; j++) begin
          cnd = (m_last + j) % N;
          if (!picked && req[cnd]) begin
            picked  = 1'b1;
            op_win  = cnd;
            op_rel  = req_rel[cnd];
            op_mask = req_mask[cnd*W +: W];
            op_val  = req_val[cnd*W +: W];
          end
        end
        op_gnt  = cyc + 2;
        have_op = 1'b1;
      end
      cyc++;
    end
  end

  logic [N-1:0] e_gnt;
  logic [W-1:0] e_drv;
  always @(negedge clk) begin
    e_gnt = '0;
    if (have_op && cyc == op_gnt) e_gnt[op_win] = 1'b1;
    e_drv = m_forced | m_held;
    chk("model gnt", gnt, e_gnt);
    chk("model busy", busy, have_op);
    chk("model forced_mask", forced_mask, m_forced);
    chk("model bus_out", bus_out, (e_drv & m_fval) | (~e_drv & in_data));
  end

  task automatic do_op(input int k, input bit rel, input logic [W-1:0] m, input logic [W-1:0] v,
                       input logic [W-1:0] exp_bus, input logic [W-1:0] exp_fm, input string nm);
    @(posedge clk); #1;
    req[k] = 1'b1; req_rel[k] = rel;
    req_mask[k*W +: W] = m; req_val[k*W +: W] = v;
    repeat (3) @(negedge clk);
    chk({nm, " gnt"}, gnt, 32'(1 << k));
    chk({nm, " bus_out"}, bus_out, exp_bus);
    chk({nm, " forced_mask"}, forced_mask, exp_fm);
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic pair(input string nm);
    @(posedge clk); #1;
    req = 2'b11; req_rel = 2'b11; req_mask = '1; req_val = '0;
    repeat (3) @(negedge clk);
    chk({nm, " first gnt"}, gnt, 32'h1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, " second gnt"}, gnt, 32'h2);
    @(posedge clk); #1;
    req[1] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  logic [N-1:0] g;
  initial begin
    rst_n = 1'b0; in_data = 4'b0101; in_we = 1'b0;
    req = '0; req_rel = '0; req_mask = '0; req_val = '0;
    repeat (2) @(negedge clk);
    chk("reset bus_out", bus_out, 32'h5);
    chk("reset forced_mask", forced_mask, 32'h0);
    chk("reset busy", busy, 32'h0);
    chk("reset gnt", gnt, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_op(0, 1'b0, 4'b1111, 4'b0111, 4'b0111, 4'b1111, "force all");
    do_op(0, 1'b1, 4'b1111, 4'b0000, 4'b0101, 4'b0000, "release all");
    do_op(0, 1'b0, 4'b0011, 4'b0010, 4'b0110, 4'b0011, "force low2");
    do_op(0, 1'b1, 4'b0001, 4'b0000, 4'b0111, 4'b0010, "release bit0");
    do_op(0, 1'b1, 4'b1111, 4'b0000, 4'b0101, 4'b0000, "release rest");

    pulse_reset();
    pair("pair1");
    pair("pair2");

    do_op(1, 1'b1, 4'b1111, 4'b0000, 4'b0101, 4'b0000, "release unforced");
    do_op(0, 1'b0, 4'b0000, 4'b1111, 4'b0101, 4'b0000, "zero mask");

    // reset during APPLY discards the op
    @(posedge clk); #1;
    req[0] = 1'b1; req_rel[0] = 1'b0; req_mask[3:0] = 4'b1111; req_val[3:0] = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk("apply-reset bus_out", bus_out, 32'h5);
    chk("apply-reset busy", busy, 32'h0);
    chk("apply-reset forced_mask", forced_mask, 32'h0);
    chk("apply-reset gnt", gnt, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-reset gnt", gnt, 32'h0);
    end

    do_op(0, 1'b0, 4'b1111, 4'b1010, 4'b1010, 4'b1111, "force 1010");
`ifdef FORCE_CTRL_HOLD_ON_RELEASE_EN
    do_op(0, 1'b1, 4'b1111, 4'b0000, 4'b1010, 4'b0000, "release held");
    @(negedge clk);
    chk("held bus_out", bus_out, 32'hA);
`else
    do_op(0, 1'b1, 4'b1111, 4'b0000, 4'b0101, 4'b0000, "release follow");
`endif
    @(posedge clk); #1 in_we = 1'b1;
    @(posedge clk); #1 in_we = 1'b0;
    @(negedge clk);
    chk("after in_we bus_out", bus_out, 32'h5);

    // randomized traffic; requests hold until granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      rst_n   = ($urandom_range(299) != 0);
      in_data = 4'($urandom);
      in_we   = ($urandom_range(3) == 0);
      for (int k = 0; k < N; k++) begin
        if ((req[k] && g[k] && $urandom_range(1) == 0) || (!req[k] && $urandom_range(4) < 2)) begin
          req[k] = 1'b1;
          req_rel[k] = 1'($urandom);
          req_mask[k*W +: W] = 4'($urandom);
          req_val[k*W +: W]  = 4'($urandom);
        end else if (req[k] && g[k]) begin
          req[k] = 1'b0;
        end
      end
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_force_ctrl.md
BUS_FORCE_CTRL -- requirements
Module: bus_force_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the bus width in bits.
REQ-002 SHALL have parameter NREQ, default 2, the number of requesters (2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  WIDTH  normal (unforced) driver value.
REQ-006 SHALL have port in_we  input  1  normal-driver update strobe; used only under REQ-027.
REQ-007 SHALL have port req  input  NREQ  per-requester request; held high until its gnt.
REQ-008 SHALL have port req_rel  input  NREQ  per-requester op: 0 = force, 1 = release.
REQ-009 SHALL have port req_mask  input  NREQ*WIDTH  per-requester bit select, requester k at [k*WIDTH +: WIDTH].
REQ-010 SHALL have port req_val  input  NREQ*WIDTH  per-requester force value, same packing.
REQ-011 SHALL have port gnt  output  NREQ  one-cycle completion pulse to the served requester.
REQ-012 SHALL have port bus_out  output  WIDTH  resolved bus value.
REQ-013 SHALL have port forced_mask  output  WIDTH  bits currently forced.
REQ-014 SHALL have port busy  output  1  high while the state machine is not IDLE.

Function
REQ-015 SHALL have bus_out[i] = forced_mask[i] ? fval[i] : in_data[i], combinational from registered fval/forced_mask and in_data.
REQ-016 SHALL implement states IDLE -> APPLY -> ACK -> IDLE, one cycle each outside IDLE.
REQ-017 SHALL, in IDLE with any req high, pick a winner round-robin, capture its req_rel/req_mask/req_val at that edge, and enter APPLY.
REQ-018 SHALL, on the APPLY exit edge: force op sets forced_mask |= mask and fval[i] = val[i] for mask bits; release op sets forced_mask &= ~mask.
REQ-019 SHALL assert gnt[winner] only during ACK; bus_out reflects the op in that same cycle (request at cycle N -> gnt and new bus_out at N+2).
REQ-020 SHALL start round-robin search at the requester after the last winner; the pointer updates on the ACK exit edge; first search after reset starts at requester 0.
REQ-021 SHALL ignore req while busy; a req still high in the cycle after its gnt is a new request.
REQ-022 SHALL overwrite fval on a force to an already-forced bit; SHALL treat a release of an unforced bit as a no-op that still completes with gnt.
REQ-023 SHALL treat an all-zero mask as a no-op that still completes with gnt.

Reset
REQ-024 SHALL on rst_n low, at any state including mid-APPLY, immediately clear forced_mask, fval, gnt, the held mask (REQ-027), and the round-robin pointer, and enter IDLE; busy = 0 and bus_out = in_data.
REQ-025 SHALL discard a captured-but-unapplied op when reset asserts; no gnt for it after reset.

Configuration
REQ-026 SHALL, without FORCE_CTRL_HOLD_ON_RELEASE_EN, make released bits follow in_data in the ACK cycle; in_we has no effect.
REQ-027 SHALL, with FORCE_CTRL_HOLD_ON_RELEASE_EN, set a held bit for each released, previously forced bit; held bits keep driving fval until the next edge with in_we = 1, which clears all held bits; bus_out[i] = (forced_mask[i] | held[i]) ? fval[i] : in_data[i]; a force on a held bit clears held and forces.

Verification (WIDTH=4, NREQ=2, in_data=4'b0101)
REQ-028 SHALL check: req0 force mask 1111 val 0111 at cycle N -> gnt[0] and bus_out=0111, forced_mask=1111 at N+2; then release mask 1111 -> bus_out=0101.
REQ-029 SHALL check: force mask 0011 val 0010 -> bus_out=0110; release mask 0001 -> 0111; release mask 1111 -> 0101.
REQ-030 SHALL check: req0 and req1 high in the same IDLE cycle -> gnt[0] at N+2, gnt[1] at N+5; the next simultaneous pair serves requester 0 first, since the last winner was requester 1.
REQ-031 SHALL check: release mask 1111 with nothing forced -> gnt pulses, bus_out stays 0101, forced_mask stays 0000.
REQ-032 SHALL check: rst_n low during APPLY of force 1111 -> gnt never pulses, bus_out=0101, busy=0, forced_mask=0000.
REQ-033 SHALL check, with FORCE_CTRL_HOLD_ON_RELEASE_EN: force 1111 val 1010 then release 1111 -> bus_out stays 1010; one in_we pulse -> bus_out=0101.
